// File: rtl/branch_pkg.sv
// Shared definitions for the branch/PC unit: RV32I branch funct3 codes,
// 2-bit BHT counter states and the saturating counter update.
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_ctr_e;

   // Saturating step toward the resolved direction.
   function automatic bht_ctr_e bht_next(input bht_ctr_e cur, input logic taken);
      bht_ctr_e nxt;
      nxt = cur;
      case (cur)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = WNT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational RV32I conditional-branch comparator: funct3, rs1, rs2 -> taken.
// Reserved funct3 codes (010/011) resolve as not-taken.
module branch_cmp
   import branch_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            taken
);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = (rs1 == rs2);
         F3_BNE:  taken = (rs1 != rs2);
         F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
         F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
         F3_BLTU: taken = (rs1 <  rs2);
         F3_BGEU: taken = (rs1 >= rs2);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC register, 2-bit BHT prediction in ID and branch/JALR resolution in EX.
// Optional perf counters (perf_branches, perf_mispredicts) under BRANCH_PERF_EN.
module branch_pc_unit
   import branch_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     BHT_DEPTH = 16,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   output logic [XLEN-1:0] if_pc,
   input  logic            id_valid,
   input  logic            id_branch,
   input  logic            id_jal,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_imm,
   output logic            id_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic            ex_jal,
   input  logic            ex_jalr,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   output logic            flush_if,
   output logic            flush_id,
   output logic            ex_redirect
`ifdef BRANCH_PERF_EN
   ,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
`endif
);

   localparam int unsigned     IDX_W   = $clog2(BHT_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   bht_ctr_e        bht [BHT_DEPTH];
   logic [IDX_W-1:0] id_idx;
   logic [IDX_W-1:0] ex_idx;
   logic            ex_taken;
   logic            id_redirect;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] ex_target;
   logic [XLEN-1:0] next_pc;

   // JAL is decoded and never mispredicts, so ex_jal needs no handling here.
   logic unused_ex_jal;
   assign unused_ex_jal = ex_jal;

   assign id_idx = id_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .funct3 (ex_funct3),
      .rs1    (ex_rs1),
      .rs2    (ex_rs2),
      .taken  (ex_taken)
   );

   assign id_pred_taken = id_valid & (id_jal | (id_branch & bht[id_idx][1]));

   assign ex_redirect = ex_valid & (ex_jalr | (ex_branch & (ex_taken != ex_pred_taken)));

   assign jalr_sum = ex_rs1 + ex_imm;

   always_comb begin
      ex_target = ex_pc + PC_STEP;
      if (ex_jalr) begin
         ex_target = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (ex_taken) begin
         ex_target = ex_pc + ex_imm;
      end
   end

   assign id_redirect = id_pred_taken & ~stall & ~ex_redirect;
   assign flush_if    = ex_redirect | id_redirect;
   assign flush_id    = ex_redirect;

   // EX redirect wins even over stall; a stall only freezes sequential fetch.
   always_comb begin
      next_pc = if_pc + PC_STEP;
      if (ex_redirect) begin
         next_pc = ex_target;
      end else if (id_redirect) begin
         next_pc = id_pc + id_imm;
      end else if (stall) begin
         next_pc = if_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_pc <= RESET_PC;
      end else begin
         if_pc <= next_pc;
      end
   end

   // Written at the edge only, so an ID read of the same index sees the old value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
            bht[i] <= WNT;
         end
      end else if (ex_valid & ex_branch) begin
         bht[ex_idx] <= bht_next(bht[ex_idx], ex_taken);
      end
   end

`ifdef BRANCH_PERF_EN
   logic branch_mispredict;

   assign branch_mispredict = ex_valid & ex_branch & ~ex_jalr & (ex_taken != ex_pred_taken);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         if (ex_valid & ex_branch) begin
            perf_branches <= perf_branches + 32'd1;
         end
         if (branch_mispredict) begin
            perf_mispredicts <= perf_mispredicts + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios plus a randomized
// run against a behavioural model of fetch PC, BHT and perf counters.
module tb_branch_pc_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n, stall;
   logic [31:0] if_pc;
   logic        id_valid, id_branch, id_jal;
   logic [31:0] id_pc, id_imm;
   logic        id_pred_taken;
   logic        ex_valid, ex_branch, ex_jal, ex_jalr;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
   logic        ex_pred_taken;
   logic        flush_if, flush_id, ex_redirect;
`ifdef BRANCH_PERF_EN
   logic [31:0] perf_branches, perf_mispredicts;
`endif

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [31:0] m_pc;
   int          m_bht [16];
   logic [31:0] m_pb, m_pm;
   logic        e_pred, e_redir, e_fif, e_fid, e_tk;
   logic [31:0] e_npc;

   always #5 clk = ~clk;

   branch_pc_unit #(
      .XLEN      (32),
      .BHT_DEPTH (16),
      .RESET_PC  (RPC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .if_pc         (if_pc),
      .id_valid      (id_valid),
      .id_branch     (id_branch),
      .id_jal        (id_jal),
      .id_pc         (id_pc),
      .id_imm        (id_imm),
      .id_pred_taken (id_pred_taken),
      .ex_valid      (ex_valid),
      .ex_branch     (ex_branch),
      .ex_jal        (ex_jal),
      .ex_jalr       (ex_jalr),
      .ex_funct3     (ex_funct3),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .ex_pc         (ex_pc),
      .ex_imm        (ex_imm),
      .ex_pred_taken (ex_pred_taken),
      .flush_if      (flush_if),
      .flush_id      (flush_id),
      .ex_redirect   (ex_redirect)
`ifdef BRANCH_PERF_EN
      ,
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
`endif
   );

   function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_eval();
      logic idr;
      e_pred  = id_valid && (id_jal || (id_branch && m_bht[(id_pc / 4) % 16] >= 2));
      e_tk    = ref_taken(ex_funct3, ex_rs1, ex_rs2);
      e_redir = ex_valid && (ex_jalr || (ex_branch && (e_tk != ex_pred_taken)));
      idr     = e_pred && !stall && !e_redir;
      e_fif   = e_redir || idr;
      e_fid   = e_redir;
      if (!rst_n)       e_npc = RPC;
      else if (e_redir) e_npc = ex_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (e_tk ? ex_pc + ex_imm : ex_pc + 32'd4);
      else if (idr)     e_npc = id_pc + id_imm;
      else if (stall)   e_npc = m_pc;
      else              e_npc = m_pc + 32'd4;
   endtask

   task automatic tick();
      int ix;
      model_eval();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_bht[i] = 1;
         m_pb = 0;
         m_pm = 0;
      end else if (ex_valid && ex_branch) begin
         ix = (ex_pc / 4) % 16;
         m_bht[ix] = e_tk ? ((m_bht[ix] == 3) ? 3 : m_bht[ix] + 1) : ((m_bht[ix] == 0) ? 0 : m_bht[ix] - 1);
         m_pb = m_pb + 1;
         if (!ex_jalr && (e_tk != ex_pred_taken)) m_pm = m_pm + 1;
      end
      m_pc = e_npc;
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; id_valid = 0; id_branch = 0; id_jal = 0; id_pc = '0; id_imm = '0;
      ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0; ex_funct3 = '0;
      ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_imm = '0; ex_pred_taken = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      tick();
      checks++; if (if_pc !== RPC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", if_pc, RPC); end
      checks++; if ({flush_if, flush_id, ex_redirect, id_pred_taken} !== 4'b0) begin failures++; $display("FAIL reset_outs got=%b exp=0000", {flush_if, flush_id, ex_redirect, id_pred_taken}); end
      rst_n = 1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (if_pc !== RPC + 32'(4 * i)) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", i, if_pc, RPC + 32'(4 * i)); end
      end
      id_valid = 1; id_branch = 1; id_pc = 32'h200;
      #1;
      checks++; if (id_pred_taken !== 1'b0) begin failures++; $display("FAIL cold_pred got=%b exp=0", id_pred_taken); end
      clear_inputs();
   endtask

   task automatic set_beq(input logic [31:0] b, input logic pred);
      clear_inputs();
      ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b000; ex_rs1 = 32'd5; ex_rs2 = b;
      ex_pc = 32'h200; ex_imm = 32'h40; ex_pred_taken = pred;
   endtask

   task automatic probe_pred(input logic exp, input string nm);
      clear_inputs();
      id_valid = 1; id_branch = 1; id_pc = 32'h200;
      #1;
      checks++; if (id_pred_taken !== exp) begin failures++; $display("FAIL %s got=%b exp=%b", nm, id_pred_taken, exp); end
      clear_inputs();
   endtask

   task automatic test_beq();
      set_beq(32'd5, 1'b0);
      #1;
      checks++; if ({ex_redirect, flush_if, flush_id} !== 3'b111) begin failures++; $display("FAIL beq_flush got=%b exp=111", {ex_redirect, flush_if, flush_id}); end
      tick();
      checks++; if (if_pc !== 32'h240) begin failures++; $display("FAIL beq_target got=%h exp=00000240", if_pc); end
      probe_pred(1'b1, "bht_01_to_10");
      for (int i = 0; i < 2; i++) begin
         set_beq(32'd5, 1'b1);
         #1;
         checks++; if (ex_redirect !== 1'b0) begin failures++; $display("FAIL beq_correct%0d got=%b exp=0", i, ex_redirect); end
         tick();
         checks++; if (if_pc !== m_pc) begin failures++; $display("FAIL beq_seq%0d got=%h exp=%h", i, if_pc, m_pc); end
      end
      set_beq(32'd6, 1'b1);
      #1;
      checks++; if (ex_redirect !== 1'b1) begin failures++; $display("FAIL beq_nt_redirect got=%b exp=1", ex_redirect); end
      tick();
      checks++; if (if_pc !== 32'h204) begin failures++; $display("FAIL beq_nt_target got=%h exp=00000204", if_pc); end
      probe_pred(1'b1, "bht_11_to_10");
      set_beq(32'd6, 1'b1);
      tick();
      probe_pred(1'b0, "bht_10_to_01");
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic        pred;
      logic        redir;
      logic [31:0] tgt;
   } cmp_vec_t;

   task automatic test_compare();
      cmp_vec_t tbl [6];
      logic [31:0] exp_pc;
      tbl[0] = '{3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h410};
      tbl[1] = '{3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0};
      tbl[2] = '{3'b010, 32'd7,         32'd7, 1'b1, 1'b1, 32'h404};
      tbl[3] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'h404};
      tbl[4] = '{3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h410};
      tbl[5] = '{3'b001, 32'd3,         32'd3, 1'b0, 1'b0, 32'h0};
      for (int i = 0; i < 6; i++) begin
         clear_inputs();
         ex_valid = 1; ex_branch = 1; ex_funct3 = tbl[i].f3; ex_rs1 = tbl[i].a; ex_rs2 = tbl[i].b;
         ex_pc = 32'h400; ex_imm = 32'h10; ex_pred_taken = tbl[i].pred;
         #1;
         checks++; if (ex_redirect !== tbl[i].redir) begin failures++; $display("FAIL cmp%0d_redirect got=%b exp=%b", i, ex_redirect, tbl[i].redir); end
         exp_pc = tbl[i].redir ? tbl[i].tgt : m_pc + 32'd4;
         tick();
         checks++; if (if_pc !== exp_pc) begin failures++; $display("FAIL cmp%0d_pc got=%h exp=%h", i, if_pc, exp_pc); end
      end
      clear_inputs();
   endtask

   task automatic test_jal();
      logic [31:0] held;
      clear_inputs();
      id_valid = 1; id_jal = 1; id_pc = 32'h300; id_imm = 32'hFFFF_FFF8; stall = 1;
      held = m_pc;
      #1;
      checks++; if ({id_pred_taken, flush_if} !== 2'b10) begin failures++; $display("FAIL jal_stall_outs got=%b exp=10", {id_pred_taken, flush_if}); end
      tick();
      checks++; if (if_pc !== held) begin failures++; $display("FAIL jal_stall_hold got=%h exp=%h", if_pc, held); end
      stall = 0;
      #1;
      checks++; if ({flush_if, flush_id} !== 2'b10) begin failures++; $display("FAIL jal_flush got=%b exp=10", {flush_if, flush_id}); end
      tick();
      checks++; if (if_pc !== 32'h2F8) begin failures++; $display("FAIL jal_target got=%h exp=000002f8", if_pc); end
      ex_valid = 1; ex_jalr = 1; ex_rs1 = 32'h1001; ex_imm = 32'd2;
      #1;
      checks++; if ({ex_redirect, flush_if, flush_id} !== 3'b111) begin failures++; $display("FAIL jalr_flush got=%b exp=111", {ex_redirect, flush_if, flush_id}); end
      tick();
      checks++; if (if_pc !== 32'h1002) begin failures++; $display("FAIL jalr_target got=%h exp=00001002", if_pc); end
      stall = 1; ex_rs1 = 32'h2000; ex_imm = 32'd5;
      tick();
      checks++; if (if_pc !== 32'h2004) begin failures++; $display("FAIL jalr_over_stall got=%h exp=00002004", if_pc); end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      int kind;
      rst_n = 0;
      clear_inputs();
      tick();
      for (int cyc = 0; cyc < 500; cyc++) begin
         rst_n     = ($urandom_range(0, 80) != 0);
         stall     = ($urandom_range(0, 3) == 0);
         kind      = $urandom_range(0, 3);
         id_valid  = (kind != 0);
         id_branch = (kind == 1) || (kind == 2);
         id_jal    = (kind == 3);
         id_pc     = {$urandom_range(0, 255), 2'b00};
         id_imm    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128) << 1;
         kind      = $urandom_range(0, 4);
         ex_valid  = (kind != 0);
         ex_branch = (kind == 1) || (kind == 2);
         ex_jal    = (kind == 3);
         ex_jalr   = (kind == 4);
         ex_funct3 = 3'($urandom_range(0, 7));
         ex_rs1    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         ex_rs2    = ($urandom_range(0, 2) == 0) ? ex_rs1 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
         ex_pc     = ($urandom_range(0, 3) == 0) ? id_pc : {$urandom_range(0, 255), 2'b00};
         ex_imm    = ($urandom_range(0, 7) == 0) ? $urandom : {{20{1'b0}}, 12'($urandom_range(0, 4095))};
         ex_pred_taken = 1'($urandom_range(0, 1));
         #1;
         model_eval();
         checks++; if (id_pred_taken !== e_pred) begin failures++; $display("FAIL rnd%0d_pred got=%b exp=%b", cyc, id_pred_taken, e_pred); end
         checks++; if (ex_redirect !== e_redir) begin failures++; $display("FAIL rnd%0d_redirect got=%b exp=%b", cyc, ex_redirect, e_redir); end
         checks++; if ({flush_if, flush_id} !== {e_fif, e_fid}) begin failures++; $display("FAIL rnd%0d_flush got=%b exp=%b", cyc, {flush_if, flush_id}, {e_fif, e_fid}); end
         tick();
         checks++; if (if_pc !== m_pc) begin failures++; $display("FAIL rnd%0d_pc got=%h exp=%h", cyc, if_pc, m_pc); end
`ifdef BRANCH_PERF_EN
         checks++; if ({perf_branches, perf_mispredicts} !== {m_pb, m_pm}) begin failures++; $display("FAIL rnd%0d_perf got=%0d/%0d exp=%0d/%0d", cyc, perf_branches, perf_mispredicts, m_pb, m_pm); end
`endif
      end
      rst_n = 1;
      clear_inputs();
   endtask

`ifdef BRANCH_PERF_EN
   task automatic run_br(input logic [2:0] f, input logic [31:0] b, input logic pred);
      clear_inputs();
      ex_valid = 1; ex_branch = 1; ex_funct3 = f; ex_rs1 = 32'd1; ex_rs2 = b;
      ex_pc = 32'h600; ex_imm = 32'h20; ex_pred_taken = pred;
      tick();
   endtask

   task automatic test_perf();
      clear_inputs();
      rst_n = 0;
      tick();
      rst_n = 1;
      run_br(3'b000, 32'd1, 1'b1);
      run_br(3'b000, 32'd2, 1'b1);
      clear_inputs();
      ex_valid = 1; ex_jalr = 1; ex_rs1 = 32'h800;
      tick();
      run_br(3'b001, 32'd2, 1'b0);
      run_br(3'b001, 32'd1, 1'b0);
      clear_inputs();
      checks++; if (perf_branches !== 32'd4) begin failures++; $display("FAIL perf_branches got=%0d exp=4", perf_branches); end
      checks++; if (perf_mispredicts !== 32'd2) begin failures++; $display("FAIL perf_mispredicts got=%0d exp=2", perf_mispredicts); end
      rst_n = 0;
      tick();
      checks++; if ({perf_branches, perf_mispredicts} !== 64'd0) begin failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_branches, perf_mispredicts); end
      rst_n = 1;
   endtask
`endif

   initial begin
      m_pc = '0; m_pb = '0; m_pm = '0;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      test_reset();
      test_beq();
      test_compare();
      test_jal();
      test_back_to_back();
`ifdef BRANCH_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Next-generation branch/PC block for the pipelined RV32I core. It replaces the single-cycle combinational branch decision.
- Owns the fetch PC register and a BHT of 2-bit saturating counters, so conditional branches are predicted in ID.
- Resolves all six RV32I conditional branches plus JAL/JALR in EX, and redirects/flushes on mispredict.
- Sits between IF (consumes if_pc) and the ID/EX pipeline registers (supplies predictions, consumes resolution).

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_DEPTH, 16, BHT entries; power of two, at least 2; index = pc[log2(BHT_DEPTH)+1:2].
- RESET_PC, 32'h0000_0000, value loaded into if_pc on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hazard stall; holds PC and blocks ID-stage redirect.
- if_pc  out  XLEN  current fetch PC (register).
- id_valid  in  1  ID holds a valid instruction.
- id_branch  in  1  ID instruction is a conditional branch.
- id_jal  in  1  ID instruction is JAL.
- id_pc  in  XLEN  PC of ID instruction.
- id_imm  in  XLEN  sign-extended B/J immediate of ID instruction.
- id_pred_taken  out  1  prediction for ID instruction (combinational); pipelined to EX by ID/EX register.
- ex_valid  in  1  EX holds a valid instruction.
- ex_branch  in  1  EX is a conditional branch.
- ex_jal  in  1  EX is JAL.
- ex_jalr  in  1  EX is JALR.
- ex_funct3  in  3  branch funct3.
- ex_rs1  in  XLEN  rs1 value (forwarded).
- ex_rs2  in  XLEN  rs2 value (forwarded).
- ex_pc  in  XLEN  PC of EX instruction.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_pred_taken  in  1  prediction carried from ID.
- flush_if  out  1  squash IF/ID register this cycle.
- flush_id  out  1  squash ID/EX register this cycle.
- ex_redirect  out  1  EX redirect (mispredict or JALR).

Behaviour:
- Reset, with rst_n low at a rising edge:
  - if_pc <= RESET_PC.
  - Every BHT entry <= 2'b01 (weakly not-taken).
  - Perf counters, if enabled, <= 0.
  - Combinational outputs are 0 while the inputs are 0. Reset mid-operation discards any pending redirect.
- Prediction (ID, combinational):
  - id_pred_taken = id_valid & (id_jal | (id_branch & BHT[idx(id_pc)][1])).
- Resolution (EX, combinational):
  - Taken per funct3: BEQ 000 (rs1==rs2), BNE 001 (!=), BLT 100 (signed <), BGE 101 (signed >=), BLTU 110 (unsigned <), BGEU 111 (unsigned >=).
  - funct3 010/011 resolve as not-taken.
- ex_redirect = ex_valid & (ex_jalr | (ex_branch & (taken != ex_pred_taken))). JAL never redirects in EX.
- EX target:
  - JALR: (ex_rs1 + ex_imm) & ~1.
  - Branch taken: ex_pc + ex_imm.
  - Branch not taken: ex_pc + 4.
  - All adds are modulo 2^XLEN; wrap-around is legal.
- ID redirect = id_pred_taken & !stall & !ex_redirect; target id_pc + id_imm.
- Next-PC priority:
  1. ex_redirect target (overrides stall).
  2. ID redirect target.
  3. stall holds if_pc.
  4. Otherwise if_pc + 4.
- flush_if = ex_redirect | ID redirect. flush_id = ex_redirect. Latency: the redirect target appears on if_pc on the edge after the triggering cycle.
- BHT update, on an edge when ex_valid & ex_branch:
  - Entry idx(ex_pc) increments (taken) or decrements (not taken).
  - Saturates at 2'b11 and 2'b00.
- BHT read/write to the same index in the same cycle: the ID read sees the old value. There is no write bypass.
- Stall does not block the BHT update. The EX instruction is resolved regardless of stall.

Optional Feature:
- Macro: BRANCH_PERF_EN.
- When defined:
  - Adds outputs perf_branches [31:0] and perf_mispredicts [31:0].
  - perf_branches counts each resolved ex_valid & ex_branch.
  - perf_mispredicts counts each ex_redirect caused by a branch; JALR is excluded.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: no such ports and no counter logic.

Decomposition:
- Shared package branch_pkg holds:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - 2-bit counter encodings SNT=00, WNT=01, WT=10, ST=11.
- Sub-module branch_cmp (combinational): funct3, rs1, rs2 -> taken. It is instantiated once.

Test Plan:
- Reset with RESET_PC=32'h100, no stall, no branches, 3 cycles -> if_pc 0x100, 0x104, 0x108, 0x10C. Cold BHT gives id_pred_taken=0 for a branch.
- BEQ in EX with rs1=rs2=5, ex_pc=0x200, imm=0x40, pred 0 -> ex_redirect=1, flush_if=flush_id=1, next if_pc=0x240. Entry 01->10.
- Same branch taken 2 more times, then not taken -> counter 10->11->11->10. The final not-taken has pred 1 -> redirect to 0x204.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU on the same operands -> not taken. funct3=010 -> not taken.
- ID JAL (id_pc=0x300, imm=-8) with stall=1 -> no redirect, if_pc held. With stall=0 -> if_pc=0x2F8, flush_if=1, flush_id=0. With a simultaneous EX JALR (rs1=0x1001, imm=2) -> if_pc=0x1002.
- With BRANCH_PERF_EN, run 4 branches including 2 mispredicts plus 1 JALR -> perf_branches=4, perf_mispredicts=2. Assert rst_n=0 mid-run -> both counters 0 on the next edge.
